// File: rtl/mac_ctrl_pkg.sv
// MAC Control constants, parser state encoding and header byte helpers
// shared by the PAUSE receive decoder.
package mac_ctrl_pkg;

  localparam logic [15:0] MAC_CTRL_ETYPE = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE   = 16'h0001;
  localparam logic [47:0] PAUSE_MCAST_DA = 48'h0180C2000001;

  localparam logic [4:0] DA_LAST_IDX    = 5'd5;
  localparam logic [4:0] ETYPE_IDX      = 5'd12;
  localparam logic [4:0] OPCODE_LSB_IDX = 5'd15;
  localparam logic [4:0] QUANTA_HI_IDX  = 5'd16;
  localparam logic [4:0] QUANTA_LO_IDX  = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_TAIL,
    S_DROP
  } parser_state_e;

  // DA byte at wire position idx (0 = most significant octet).
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [4:0] idx);
    case (idx)
      5'd0:    return addr[47:40];
      5'd1:    return addr[39:32];
      5'd2:    return addr[31:24];
      5'd3:    return addr[23:16];
      5'd4:    return addr[15:8];
      5'd5:    return addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Expected EtherType/opcode byte at wire positions 12..15.
  function automatic logic [7:0] ctrl_byte(input logic [4:0] idx);
    case (idx)
      5'd12:   return MAC_CTRL_ETYPE[15:8];
      5'd13:   return MAC_CTRL_ETYPE[7:0];
      5'd14:   return PAUSE_OPCODE[15:8];
      5'd15:   return PAUSE_OPCODE[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pause_quanta_timer.sv
// Pause quanta timer: counts SLOT_CYCLES clocks per quantum and holds
// tx_pause while quanta remain. A load always overrides the countdown.
module pause_quanta_timer #(
  parameter int SLOT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] quanta,
  output logic        tx_pause,
  output logic [15:0] quanta_rem
);

  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);

  logic [SLOT_W-1:0] slot_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      quanta_rem <= '0;
      tx_pause   <= 1'b0;
    end else if (load) begin
      slot_cnt   <= SLOT_LAST;
      quanta_rem <= quanta;
      tx_pause   <= (quanta != 16'd0);
    end else if (quanta_rem != 16'd0) begin
      if (slot_cnt == '0) begin
        slot_cnt   <= SLOT_LAST;
        quanta_rem <= quanta_rem - 16'd1;
        tx_pause   <= (quanta_rem != 16'd1);
      end else begin
        slot_cnt <= slot_cnt - SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pause_rx_decoder.sv
// Receive-side PAUSE frame decoder: parses the MAC receive byte stream and
// loads the pause quanta timer when a well-formed PAUSE frame ends cleanly.
module pause_rx_decoder
  import mac_ctrl_pkg::*;
#(
  parameter logic [47:0] STATION_ADDR = 48'h000000000000,
  parameter int          SLOT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_mac_data,
  input  logic        rx_mac_valid,
  input  logic        rx_mac_last,
  input  logic        rx_frame_err,
  output logic        tx_pause,
  output logic [15:0] pause_quanta_rem,
  output logic [15:0] pause_frame_cnt
);

  parser_state_e state;
  logic [4:0]    idx;
  logic          mc_ok;
  logic          st_ok;
  logic [15:0]   quanta_q;

  logic [4:0]    cur_idx;
  logic [4:0]    idx_next;
  logic          mc_hit;
  logic          st_hit;
  logic          byte_ok;
  logic          load;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    cur_idx  = (state == S_IDLE) ? 5'd0 : idx;
    idx_next = (cur_idx == 5'd31) ? 5'd31 : cur_idx + 5'd1;
    mc_hit   = ((state == S_IDLE) || mc_ok) &&
               (rx_mac_data == addr_byte(PAUSE_MCAST_DA, cur_idx));
    st_hit   = ((state == S_IDLE) || st_ok) &&
               (rx_mac_data == addr_byte(STATION_ADDR, cur_idx));
    byte_ok  = 1'b1;
    if (cur_idx <= DA_LAST_IDX) begin
      byte_ok = mc_hit || st_hit;
    end else if (cur_idx >= ETYPE_IDX && cur_idx <= OPCODE_LSB_IDX) begin
      byte_ok = (rx_mac_data == ctrl_byte(cur_idx));
    end
    load = (state == S_TAIL) && rx_mac_valid && rx_mac_last && !rx_frame_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      idx             <= '0;
      mc_ok           <= 1'b0;
      st_ok           <= 1'b0;
      quanta_q        <= '0;
      pause_frame_cnt <= '0;
    end else begin
      if (load) pause_frame_cnt <= pause_frame_cnt + 16'd1;
      if (rx_mac_valid) begin
        idx <= idx_next;
        case (state)
          S_IDLE, S_HDR: begin
            if (cur_idx <= DA_LAST_IDX) begin
              mc_ok <= mc_hit;
              st_ok <= st_hit;
            end
            if (cur_idx == QUANTA_HI_IDX) quanta_q[15:8] <= rx_mac_data;
            if (cur_idx == QUANTA_LO_IDX) quanta_q[7:0]  <= rx_mac_data;
            // A frame ending inside the header is too short to be a PAUSE.
            if (rx_mac_last)                 state <= S_IDLE;
            else if (!byte_ok)               state <= S_DROP;
            else if (cur_idx == QUANTA_LO_IDX) state <= S_TAIL;
            else                             state <= S_HDR;
          end
          S_TAIL, S_DROP: begin
            if (rx_mac_last) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  pause_quanta_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .quanta    (quanta_q),
    .tx_pause  (tx_pause),
    .quanta_rem(pause_quanta_rem)
  );

endmodule

// File: tb/tb_pause_rx_decoder.sv
// Self-checking bench for pause_rx_decoder: directed scenarios with literal
// expectations plus randomized frames against a frame-level reference model.
module tb_pause_rx_decoder;

  localparam int          SLOT    = 64;
  localparam logic [47:0] STATION = 48'h02AABBCCDDEE;
  localparam logic [47:0] MCAST   = 48'h0180C2000001;

  typedef logic [7:0] byte_t;
  typedef byte_t bytes_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_mac_data;
  logic        rx_mac_valid;
  logic        rx_mac_last;
  logic        rx_frame_err;
  logic        tx_pause;
  logic [15:0] pause_quanta_rem;
  logic [15:0] pause_frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: cycles of pause left, accepted frame count, bytes so far.
  int          m_r;
  logic [15:0] m_cnt;
  bytes_t      fbuf;

  pause_rx_decoder #(
    .STATION_ADDR(STATION),
    .SLOT_CYCLES (SLOT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_mac_data     (rx_mac_data),
    .rx_mac_valid    (rx_mac_valid),
    .rx_mac_last     (rx_mac_last),
    .rx_frame_err    (rx_frame_err),
    .tx_pause        (tx_pause),
    .pause_quanta_rem(pause_quanta_rem),
    .pause_frame_cnt (pause_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // b holds every byte of the frame except the last one.
  function automatic bit model_accept(input bytes_t b);
    logic [47:0] da;
    if (b.size() < 18) return 1'b0;
    da = {b[0], b[1], b[2], b[3], b[4], b[5]};
    if (da != MCAST && da != STATION) return 1'b0;
    if ({b[12], b[13]} != 16'h8808) return 1'b0;
    if ({b[14], b[15]} != 16'h0001) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_r   <= 0;
      m_cnt <= '0;
      fbuf.delete();
    end else begin
      if (rx_mac_valid && rx_mac_last && !rx_frame_err && model_accept(fbuf)) begin
        m_r   <= int'({fbuf[16], fbuf[17]}) * SLOT;
        m_cnt <= m_cnt + 16'd1;
      end else if (m_r != 0) begin
        m_r <= m_r - 1;
      end
      if (rx_mac_valid) begin
        if (rx_mac_last) fbuf.delete();
        else fbuf.push_back(rx_mac_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_pause", 32'(tx_pause), 32'(m_r != 0));
      check("quanta_rem", 32'(pause_quanta_rem), 32'((m_r + SLOT - 1) / SLOT));
      check("frame_cnt", 32'(pause_frame_cnt), 32'(m_cnt));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input byte_t d, input bit last, input bit err);
    rx_mac_valid = 1'b1;
    rx_mac_data  = d;
    rx_mac_last  = last;
    rx_frame_err = err & last;
    idle(1);
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  function automatic bytes_t make_frame(input logic [47:0] da, input logic [15:0] etype,
                                        input logic [15:0] opcode, input logic [15:0] quanta,
                                        input int len);
    bytes_t f;
    for (int i = 0; i < 6; i++) f.push_back(da[47-8*i -: 8]);
    f.push_back(8'h02);
    for (int i = 0; i < 5; i++) f.push_back(8'($urandom));
    f.push_back(etype[15:8]);
    f.push_back(etype[7:0]);
    f.push_back(opcode[15:8]);
    f.push_back(opcode[7:0]);
    f.push_back(quanta[15:8]);
    f.push_back(quanta[7:0]);
    while (f.size() < len) f.push_back(8'($urandom));
    while (f.size() > len) void'(f.pop_back());
    return f;
  endfunction

  task automatic send_frame(input bytes_t f, input bit err, input int gap_pct);
    int g;
    foreach (f[i]) begin
      g = 0;
      while (gap_pct > 0 && g < 3 && $urandom_range(99) < gap_pct) begin
        idle(1);
        g++;
      end
      drive_byte(f[i], i == f.size() - 1, err);
    end
  endtask

  task automatic measure_high(output int hi);
    hi = 0;
    while (tx_pause === 1'b1 && hi < 5000) begin
      hi++;
      idle(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int     hi;
    bytes_t f;
    int     lens[6] = '{14, 17, 19, 64, 64, 70};

    rst          = 1'b1;
    rx_mac_data  = '0;
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    rx_frame_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_tx_pause", 32'(tx_pause), 32'd0);
    check("rst_quanta_rem", 32'(pause_quanta_rem), 32'd0);
    check("rst_frame_cnt", 32'(pause_frame_cnt), 32'd0);
    rst = 1'b0;

    // Multicast PAUSE, 3 quanta.
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0003, 64), 1'b0, 0);
    check("t1_rise", 32'(tx_pause), 32'd1);
    check("t1_rem", 32'(pause_quanta_rem), 32'd3);
    measure_high(hi);
    check("t1_high_cycles", 32'(hi), 32'd192);
    check("t1_cnt", 32'(pause_frame_cnt), 32'd1);

    // Long pause cancelled by quanta 0.
    do_reset();
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0100, 64), 1'b0, 0);
    idle(1000);
    check("t2_still_paused", 32'(tx_pause), 32'd1);
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0000, 64), 1'b0, 0);
    check("t2_cancel", 32'(tx_pause), 32'd0);
    check("t2_cnt", 32'(pause_frame_cnt), 32'd2);

    // Non-control frame, errored PAUSE, runt.
    do_reset();
    send_frame(make_frame(MCAST, 16'h0800, 16'h0001, 16'h0004, 64), 1'b0, 0);
    idle(3);
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0004, 64), 1'b1, 0);
    idle(3);
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0004, 14), 1'b0, 0);
    check("t3_no_pause", 32'(tx_pause), 32'd0);
    check("t3_cnt", 32'(pause_frame_cnt), 32'd0);

    // Unicast PAUSE to the station address with valid gaps.
    do_reset();
    send_frame(make_frame(STATION, 16'h8808, 16'h0001, 16'h0002, 64), 1'b0, 40);
    measure_high(hi);
    check("t4_high_cycles", 32'(hi), 32'd128);
    check("t4_cnt", 32'(pause_frame_cnt), 32'd1);

    // Reload lands on the edge where the slot counter would wrap.
    do_reset();
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0005, 64), 1'b0, 0);
    idle(64);
    check("t5_rem_before", 32'(pause_quanta_rem), 32'd4);
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0002, 64), 1'b0, 0);
    check("t5_rem_reload", 32'(pause_quanta_rem), 32'd2);
    measure_high(hi);
    check("t5_high_cycles", 32'(hi), 32'd128);

    // Reset mid-frame aborts parsing and clears a running pause.
    do_reset();
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0010, 64), 1'b0, 0);
    f = make_frame(MCAST, 16'h8808, 16'h0001, 16'h0004, 64);
    for (int i = 0; i < 10; i++) drive_byte(f[i], 1'b0, 1'b0);
    rst          = 1'b1;
    rx_mac_valid = 1'b1;
    rx_mac_data  = f[10];
    idle(1);
    rst          = 1'b0;
    rx_mac_valid = 1'b0;
    check("t6_rst_pause", 32'(tx_pause), 32'd0);
    check("t6_rst_rem", 32'(pause_quanta_rem), 32'd0);
    send_frame(make_frame(MCAST, 16'h8808, 16'h0001, 16'h0001, 64), 1'b0, 0);
    measure_high(hi);
    check("t6_high_cycles", 32'(hi), 32'd64);
    check("t6_cnt", 32'(pause_frame_cnt), 32'd1);

    // Randomized mix, including back-to-back frames; the model checks every cycle.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [47:0] da;
      logic [15:0] et, op, q;
      int          kind, len;
      bit          err;
      kind = $urandom_range(6);
      da   = ($urandom_range(1) == 0) ? MCAST : STATION;
      et   = 16'h8808;
      op   = 16'h0001;
      q    = ($urandom_range(7) == 0) ? 16'($urandom_range(8, 40)) : 16'($urandom_range(0, 5));
      len  = 64;
      err  = 1'b0;
      case (kind)
        2: da = da ^ (48'h1 << (8 * $urandom_range(5)));
        3: et = 16'h0800;
        4: op = 16'h0002;
        5: err = 1'b1;
        6: len = lens[$urandom_range(5)];
        default: ;
      endcase
      send_frame(make_frame(da, et, op, q, len), err, $urandom_range(30));
      if ($urandom_range(3) != 0) idle($urandom_range(1, 200));
    end
    idle(3 * SLOT);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
